// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: address field layout and widths for the instruction cache.
`default_nettype none

package cpu_types_pkg;

  localparam int ITAG_W = 26;
  localparam int IIDX_W = 4;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

endpackage

`default_nettype wire

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with single-word miss fill.
// Rev 1.0 - initial release.
`default_nettype none

module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_t;

  icache_state_t state_q, state_d;

  logic              valid_q [SETS];
  logic [ITAG_W-1:0] tag_q   [SETS];
  logic [31:0]       data_q  [SETS];

  icachef_t addr;
  logic     hit;
  logic     fill;
  logic     unused_bytoff;

  assign addr          = icachef_t'(imemaddr);
  assign unused_bytoff = ^addr.bytoff;
  assign hit           = imemREN & valid_q[addr.idx] & (tag_q[addr.idx] == addr.tag);
  // A completing read always fills, even when the request is being withdrawn.
  assign fill          = (state_q == MISS) & ~iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else if (fill) begin
      valid_q[addr.idx] <= 1'b1;
      tag_q[addr.idx]   <= addr.tag;
      data_q[addr.idx]  <= iload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit && !halt) begin
          state_d = MISS;
        end
      end
      MISS: begin
        if (!iwait || !imemREN || halt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = imemaddr;
    case (state_q)
      IDLE: begin
        ihit     = hit;
        imemload = hit ? data_q[addr.idx] : '0;
      end
      MISS: begin
        iREN = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for the icache.
`default_nettype none

module tb_icache;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        halt;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int nvec = 0;
  int nerr = 0;

  icache #(.SETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .halt     (halt),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    halt     = 1'b0;
    iwait    = 1'b1;
    iload    = 32'h0;
    #2;
    chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_iREN", {31'b0, iREN}, 32'd0);
    tick();
    tick();
    nRST = 1'b1;
    tick();

    // Cold miss on 0x40, memory latency 2
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    #2;
    chk("cold_c0_ihit", {31'b0, ihit}, 32'd0);
    chk("cold_c0_iREN", {31'b0, iREN}, 32'd0);
    tick();
    #2;
    chk("cold_c1_iREN", {31'b0, iREN}, 32'd1);
    chk("cold_c1_iaddr", iaddr, 32'h0000_0040);
    chk("cold_c1_ihit", {31'b0, ihit}, 32'd0);
    tick();
    iwait = 1'b0;
    iload = 32'h2402_0005;
    #2;
    chk("cold_c2_iREN", {31'b0, iREN}, 32'd1);
    tick();
    iwait = 1'b1;
    iload = 32'hDEAD_BEEF;
    #2;
    chk("cold_c3_ihit", {31'b0, ihit}, 32'd1);
    chk("cold_c3_load", imemload, 32'h2402_0005);
    chk("cold_c3_iREN", {31'b0, iREN}, 32'd0);

    // Warm hits for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      #2;
      chk("warm_ihit", {31'b0, ihit}, 32'd1);
      chk("warm_load", imemload, 32'h2402_0005);
      chk("warm_iREN", {31'b0, iREN}, 32'd0);
    end

    // Conflict: 0x80 maps to the same frame as 0x40
    imemaddr = 32'h0000_0080;
    #2;
    chk("conf_ihit", {31'b0, ihit}, 32'd0);
    tick();
    #2;
    chk("conf_iREN", {31'b0, iREN}, 32'd1);
    chk("conf_iaddr", iaddr, 32'h0000_0080);
    iwait = 1'b0;
    iload = 32'hAAAA_0080;
    tick();
    iwait = 1'b1;
    #2;
    chk("conf_fill_ihit", {31'b0, ihit}, 32'd1);
    chk("conf_fill_load", imemload, 32'hAAAA_0080);
    imemaddr = 32'h0000_0040;
    #1;
    chk("conf_back_ihit", {31'b0, ihit}, 32'd0);
    tick();
    #2;
    chk("conf_back_iREN", {31'b0, iREN}, 32'd1);
    iwait = 1'b0;
    iload = 32'h2402_0005;
    tick();
    iwait = 1'b1;
    #2;
    chk("conf_refill_load", imemload, 32'h2402_0005);

    // Abort by dropping imemREN while memory is busy
    imemaddr = 32'h0000_0044;
    #1;
    chk("abort_ihit", {31'b0, ihit}, 32'd0);
    tick();
    #2;
    chk("abort_miss_iREN", {31'b0, iREN}, 32'd1);
    imemREN = 1'b0;
    tick();
    #2;
    chk("abort_idle_iREN", {31'b0, iREN}, 32'd0);
    imemREN = 1'b1;
    #1;
    chk("abort_nofill_ihit", {31'b0, ihit}, 32'd0);
    tick();
    #2;
    chk("abort_remiss_iREN", {31'b0, iREN}, 32'd1);

    // Halt during a busy miss aborts, then no new miss while halted
    halt = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("halt_iREN", {31'b0, iREN}, 32'd0);
      chk("halt_ihit", {31'b0, ihit}, 32'd0);
      tick();
    end
    imemaddr = 32'h0000_0040;
    #2;
    chk("halt_cached_ihit", {31'b0, ihit}, 32'd1);
    chk("halt_cached_load", imemload, 32'h2402_0005);

    // Halt coinciding with completion still fills
    halt     = 1'b0;
    imemaddr = 32'h0000_0048;
    tick();
    #2;
    chk("hfill_iREN", {31'b0, iREN}, 32'd1);
    halt  = 1'b1;
    iwait = 1'b0;
    iload = 32'h1234_5678;
    tick();
    iwait = 1'b1;
    #2;
    chk("hfill_ihit", {31'b0, ihit}, 32'd1);
    chk("hfill_load", imemload, 32'h1234_5678);
    chk("hfill_iREN", {31'b0, iREN}, 32'd0);

    // Reset asserted mid-miss
    halt     = 1'b0;
    imemaddr = 32'h0000_004C;
    tick();
    #1;
    chk("rmid_iREN_before", {31'b0, iREN}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("rmid_iREN_async", {31'b0, iREN}, 32'd0);
    tick();
    nRST = 1'b1;
    imemaddr = 32'h0000_0040;
    #2;
    chk("rmid_after_ihit", {31'b0, ihit}, 32'd0);
    tick();
    #2;
    chk("rmid_after_iREN", {31'b0, iREN}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch stage and the memory controller. It answers `imemREN`/`imemaddr` from the datapath with `ihit`/`imemload`. On a miss it issues a single-word read to the memory controller over the `caches_if` icache signals, fills the frame, and then hits. There is no write path and no flush logic; frames are invalidated only by reset.

## Interface
Parameters:
- `SETS`, 16: number of frames; must equal 2^IDX_W from the shared package.

Ports (datapath side via `datapath_cache_if` cache modport, memory side via `caches_if` icache modport):
- `CLK`  in  1  clock; all state changes on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `imemREN`  in  1  fetch request from the datapath.
- `imemaddr`  in  32  fetch address (PC); word aligned.
- `halt`  in  1  datapath halted; suppresses new misses.
- `ihit`  out  1  `imemload` valid this cycle.
- `imemload`  out  32  instruction word.
- `iREN`  out  1  read request to the memory controller.
- `iaddr`  out  32  memory read address.
- `iwait`  in  1  memory busy; low marks `iload` valid.
- `iload`  in  32  memory read data.

## Operation
- Address split (package type `icachef_t`): tag[31:6] (26 b), idx[5:2] (4 b), bytoff[1:0] (ignored).
- Frame array: `SETS` × {valid, tag[25:0], data[31:0]}.
- `hit` = `imemREN` & valid[idx] & (tag[idx] == addr.tag).
- FSM state `IDLE`:
  - `ihit` = `hit`, and `imemload` = data[idx] when `hit`, else 0.
  - `iREN` = 0.
  - If `imemREN` & !`hit` & !`halt`, go to `MISS`.
- FSM state `MISS`:
  - `iREN` = 1, `iaddr` = `imemaddr`, `ihit` = 0.
  - When `iwait` = 0: write valid = 1, tag, and data = `iload` into frame idx, then go to `IDLE`.
  - If `imemREN` = 0 or `halt` = 1 while `iwait` = 1: abort, go to `IDLE`, no fill.
  - Abort has priority only while `iwait` is high. A completing read (`iwait` = 0) always fills.
- Same-index miss replaces the frame unconditionally; there is no other replacement policy.
- `iaddr` = `imemaddr` in every state. Memory ignores it unless `iREN` = 1.

## Timing
- Reset (async, `nRST` low):
  - State = `IDLE`, all valid = 0. Tags and data need not be reset.
  - `ihit` = 0, `imemload` = 0, `iREN` = 0.
- Hit latency 0: `ihit` and `imemload` are combinational from `imemaddr` in the same cycle.
- Miss, with memory latency L cycles (`iwait` high for L−1 cycles, low on the L-th cycle of `iREN`):
  - cycle 0: miss detected in `IDLE`.
  - cycles 1..L: `iREN` high.
  - edge after cycle L: frame written.
  - cycle L+1: `IDLE`, `ihit` = 1.
  - Penalty = L+1 cycles.
- `iREN` is held continuously from the `MISS` entry edge to the fill edge, with no glitch.
- If `imemaddr` changes during `MISS` while `imemREN` stays high, the fill uses the address present in the fill cycle. The datapath holds the PC during misses, so this case is legal but unrewarded.
- Reset asserted mid-miss: `iREN` drops immediately (async) and no fill occurs.
- Simultaneous `halt` and `iwait` = 0 in `MISS`: the fill completes and the next state is `IDLE`.

## Structure
- The `icachef_t` packed struct (tag/idx/bytoff) and the widths `ITAG_W` = 26 and `IIDX_W` = 4 live in `cpu_types_pkg`.
- The FSM state enum `icache_state_t` {`IDLE`, `MISS`} is local to the module.
- Single module, no sub-modules.
- The frame array is flops: one `always_ff` for frames, one for state, and one `always_comb` each for next-state and outputs.

## Test plan
- Cold miss: reset, `imemREN` = 1, `imemaddr` = 0x0000_0040, L = 2 with `iload` = 0x2402_0005.
  - `iREN` high 2 cycles, `iaddr` = 0x40.
  - Cycle 3: `ihit` = 1, `imemload` = 0x2402_0005.
- Warm hit: repeat 0x40 afterwards → `ihit` = 1 in the same cycle with `iREN` = 0, for 10 consecutive cycles.
- Conflict: fill 0x40, then request 0x80 (same idx 0, different tag) → miss, refill.
  - Returning to 0x40 misses again with `iREN` = 1.
- Abort: during `MISS` with `iwait` = 1, drop `imemREN` → next cycle `IDLE`, `iREN` = 0.
  - Re-requesting the same address misses again, confirming the frame was not written.
- Halt: `halt` = 1 with an uncached address → `iREN` stays 0 indefinitely.
  - `halt` = 1 on a cached address → `ihit` = 1.
- Reset mid-miss: drop `nRST` during `MISS` → `iREN` = 0 asynchronously.
  - After release, the previously cached 0x40 misses.
